// File: rtl/cube_pkg.sv
// Shared geometry and state encoding for the LED cube frame path.
package cube_pkg;

    localparam int ROWS    = 64;
    localparam int ROW_W   = 8;
    localparam int FRAME_W = ROWS * ROW_W;
    localparam int ADDR_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/frame_timer.sv
// Counts display scans; expire is high on the scan_wrap that completes DIV scans.
module frame_timer #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_wrap,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt;

    assign expire = scan_wrap && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (scan_wrap) begin
            cnt <= expire ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/frame_ctrl.sv
// Double-buffered frame controller: the animator fills the back bank, which is
// copied to the displayed front bank on a scan boundary.
//
//   state | meaning
//   IDLE  | front is current, waiting for the frame period to request a new frame
//   FILL  | animator is writing rows into the back bank
//   PEND  | back bank complete, waiting for the next scan_wrap to swap
module frame_ctrl
    import cube_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_wrap,
    output logic               frame_req,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ROW_W-1:0]   wr_data,
    input  logic               wr_last,
    output logic [FRAME_W-1:0] frame_cube_flat,
    output logic               swap_done,
    output logic               overrun
);

    state_t state, state_nxt;

    logic [ROW_W-1:0] front [ROWS];
    logic [ROW_W-1:0] back  [ROWS];

    logic expire;
    logic xfer;
    logic swap;
    logic req_nxt;
    logic ovr_set;

    frame_timer #(.DIV(DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .scan_wrap (scan_wrap),
        .expire    (expire)
    );

    assign wr_ready = (state == ST_FILL);
    assign xfer     = wr_valid && wr_ready;

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        swap      = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (expire) begin
                    req_nxt   = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (expire) ovr_set = 1'b1;
                if (xfer && wr_last) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                // an expiry coinciding with the swap is absorbed by the swap
                if (scan_wrap) begin
                    swap      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            frame_req <= 1'b0;
            swap_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_req <= req_nxt;
            swap_done <= swap;
            if (ovr_set) overrun <= 1'b1;
        end
    end

    // back is left intact on a swap so unwritten rows carry over to the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                front[i] <= '0;
                back[i]  <= '0;
            end
        end else begin
            if (xfer) back[wr_addr] <= wr_data;
            if (swap) begin
                for (int i = 0; i < ROWS; i++) front[i] <= back[i];
            end
        end
    end

    always_comb begin
        frame_cube_flat = '0;
        for (int i = 0; i < ROWS; i++) begin
            frame_cube_flat[i*ROW_W +: ROW_W] = front[i];
        end
    end

endmodule

// File: tb/tb_frame_ctrl.sv
// Bench for frame_ctrl: DIV=2 and DIV=1 instances share stimulus and are
// checked every cycle against a frame-level reference model plus directed checks.
module tb_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_wrap;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_last;

    logic         frame_req_v [2];
    logic         wr_ready_v  [2];
    logic         swap_done_v [2];
    logic         overrun_v   [2];
    logic [511:0] cube_v      [2];

    int n_assert = 0;
    int n_fail   = 0;

    int  m_st   [2];
    int  m_cnt  [2];
    bit  m_req  [2];
    bit  m_swap [2];
    bit  m_ovr  [2];
    logic [7:0] m_front [2][64];
    logic [7:0] m_back  [2][64];

    int req_seen  [2];
    int swap_seen [2];

    always #5 clk = ~clk;

    frame_ctrl #(.DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .scan_wrap(scan_wrap), .frame_req(frame_req_v[0]),
        .wr_valid(wr_valid), .wr_ready(wr_ready_v[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last), .frame_cube_flat(cube_v[0]),
        .swap_done(swap_done_v[0]), .overrun(overrun_v[0])
    );

    frame_ctrl #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .scan_wrap(scan_wrap), .frame_req(frame_req_v[1]),
        .wr_valid(wr_valid), .wr_ready(wr_ready_v[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last), .frame_cube_flat(cube_v[1]),
        .swap_done(swap_done_v[1]), .overrun(overrun_v[1])
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level behaviour: period = d scans; request, fill, then swap on a scan.
    task automatic model_edge(input int k, input int d);
        bit expired;
        if (rst) begin
            m_st[k] = 0; m_cnt[k] = 0;
            m_req[k] = 0; m_swap[k] = 0; m_ovr[k] = 0;
            for (int i = 0; i < 64; i++) begin
                m_front[k][i] = 8'h00;
                m_back[k][i]  = 8'h00;
            end
            return;
        end
        expired = scan_wrap && (m_cnt[k] == d - 1);
        if (scan_wrap) m_cnt[k] = (m_cnt[k] + 1) % d;
        m_req[k]  = 0;
        m_swap[k] = 0;
        if (m_st[k] == 0) begin
            if (expired) begin m_req[k] = 1; m_st[k] = 1; end
        end else if (m_st[k] == 1) begin
            if (wr_valid) m_back[k][wr_addr] = wr_data;
            if (expired) m_ovr[k] = 1;
            if (wr_valid && wr_last) m_st[k] = 2;
        end else begin
            if (scan_wrap) begin
                m_front[k] = m_back[k];
                m_swap[k]  = 1;
                m_st[k]    = 0;
            end
        end
    endtask

    function automatic logic [511:0] model_flat(input int k);
        logic [511:0] f;
        for (int i = 0; i < 64; i++) f[8*i +: 8] = m_front[k][i];
        return f;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("frame_req[%0d]", k), 512'(frame_req_v[k]), 512'(m_req[k]));
            check($sformatf("wr_ready[%0d]", k),  512'(wr_ready_v[k]),  512'(m_st[k] == 1));
            check($sformatf("swap_done[%0d]", k), 512'(swap_done_v[k]), 512'(m_swap[k]));
            check($sformatf("overrun[%0d]", k),   512'(overrun_v[k]),   512'(m_ovr[k]));
            check($sformatf("cube[%0d]", k),      cube_v[k],            model_flat(k));
            req_seen[k]  += int'(frame_req_v[k]);
            swap_seen[k] += int'(swap_done_v[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, 2);
        model_edge(1, 1);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        scan_wrap = 0; wr_valid = 0; wr_last = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wrap();
        wr_valid = 0; wr_last = 0;
        scan_wrap = 1;
        step();
        scan_wrap = 0;
    endtask

    task automatic beat(input int addr, input int data, input bit last, input bit sw);
        wr_valid  = 1;
        wr_addr   = 6'(addr);
        wr_data   = 8'(data);
        wr_last   = last;
        scan_wrap = sw;
        step();
        wr_valid = 0; wr_last = 0; scan_wrap = 0;
    endtask

    initial begin
        logic [511:0] exp_cube;
        rst = 1; scan_wrap = 0; wr_valid = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
        @(negedge clk);
        step(); step();
        check("rst frame_req", 512'(frame_req_v[0]), 512'(0));
        check("rst wr_ready",  512'(wr_ready_v[0]),  512'(0));
        check("rst swap_done", 512'(swap_done_v[0]), 512'(0));
        check("rst overrun",   512'(overrun_v[0]),   512'(0));
        check("rst cube",      cube_v[0],            512'(0));
        rst = 0;

        // first request one cycle after the second scan
        idle(15); wrap();
        check("no req after scan 1", 512'(frame_req_v[0]), 512'(0));
        idle(15); wrap();
        check("req after scan 2", 512'(frame_req_v[0]), 512'(1));
        check("ready in fill",    512'(wr_ready_v[0]),  512'(1));
        check("no overrun",       512'(overrun_v[0]),   512'(0));

        // full frame, row i = i
        for (int i = 0; i < 64; i++) beat(i, i, i == 63, 0);
        check("no ready in pend", 512'(wr_ready_v[0]), 512'(0));
        idle(10);
        check("cube held before swap", cube_v[0], 512'(0));
        swap_seen[0] = 0;
        wrap();
        for (int i = 0; i < 64; i++) exp_cube[8*i +: 8] = 8'(i);
        check("cube after full frame", cube_v[0], exp_cube);
        check("swap_done pulse", 512'(swap_done_v[0]), 512'(1));
        idle(15);
        check("swap_done once", 512'(swap_seen[0]), 512'(1));
        wrap();
        check("req 2 scans after swap", 512'(frame_req_v[0]), 512'(1));
        check("overrun still 0",        512'(overrun_v[0]),   512'(0));

        // incremental frame: only row 5
        beat(5, 8'hFF, 1, 0);
        idle(15); wrap();
        exp_cube[8*5 +: 8] = 8'hFF;
        check("incremental row 5", cube_v[0], exp_cube);

        // wr_last coincident with scan_wrap defers the swap
        idle(15); wrap();
        check("req frame 3", 512'(frame_req_v[0]), 512'(1));
        beat(9, 8'hA5, 0, 0);
        beat(10, 8'h5A, 1, 1);
        check("no swap on coincident scan", 512'(swap_done_v[0]), 512'(0));
        check("cube unchanged",             cube_v[0],            exp_cube);
        idle(15);
        req_seen[0] = 0;
        wrap();
        exp_cube[8*9 +: 8]  = 8'hA5;
        exp_cube[8*10 +: 8] = 8'h5A;
        check("deferred swap",             cube_v[0],            exp_cube);
        check("deferred swap_done",        512'(swap_done_v[0]), 512'(1));
        check("no req on swap+expiry",     512'(req_seen[0]),    512'(0));
        check("no overrun on swap+expiry", 512'(overrun_v[0]),   512'(0));
        idle(15); wrap();
        check("no req mid period", 512'(frame_req_v[0]), 512'(0));
        idle(15); wrap();
        check("req next expiry", 512'(frame_req_v[0]), 512'(1));

        // DIV=1 animator stall
        rst = 1; step(); rst = 0;
        req_seen[1] = 0;
        idle(15); wrap();
        check("div1 req",  512'(frame_req_v[1]), 512'(1));
        check("div1 fill", 512'(wr_ready_v[1]),  512'(1));
        for (int p = 0; p < 3; p++) begin idle(15); wrap(); end
        check("stall overrun", 512'(overrun_v[1]), 512'(1));
        idle(20);
        check("overrun sticky",  512'(overrun_v[1]), 512'(1));
        check("no extra req",    512'(req_seen[1]),  512'(1));

        // reset mid-fill discards the partial frame
        for (int i = 0; i < 30; i++) beat(i, $urandom_range(1, 255), 0, 0);
        rst = 1; scan_wrap = 1; wr_valid = 1; step(); rst = 0; scan_wrap = 0; wr_valid = 0;
        check("rst mid fill cube",  cube_v[0],           512'(0));
        check("rst mid fill ready", 512'(wr_ready_v[0]), 512'(0));
        swap_seen[0] = 0;
        for (int p = 0; p < 4; p++) begin idle(15); wrap(); end
        idle(3);
        check("no swap after rst", 512'(swap_seen[0]), 512'(0));
        check("blank after rst",   cube_v[0],          512'(0));

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            scan_wrap = ($urandom_range(0, 7) == 0);
            wr_valid  = $urandom_range(0, 1);
            wr_addr   = 6'($urandom);
            wr_data   = 8'($urandom);
            wr_last   = ($urandom_range(0, 11) == 0);
            step();
        end
        rst = 0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
